// File: rtl/cla_pipe_addsub.sv
// Pipelined add/subtract: one SLICE-bit carry-lookahead slice per slot, carry/borrow rippling slot to slot.
// Define CLA_ADDSUB_FLAGS_EN to add the out_zero and out_ovf result flags.
module cla_pipe_addsub #(
    parameter int unsigned WIDTH  = 32,
    parameter int unsigned SLICE  = 8,
    parameter int unsigned STAGES = 4
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             in_op,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_result,
`ifdef CLA_ADDSUB_FLAGS_EN
    output logic             out_cb,
    output logic             out_zero,
    output logic             out_ovf
`else
    output logic             out_cb
`endif
);

    localparam int unsigned LAST = STAGES - 1;

    // Generate/propagate slice; returns {carry_out, sum}.
    function automatic logic [SLICE:0] cla_slice(input logic [SLICE-1:0] a,
                                                 input logic [SLICE-1:0] b,
                                                 input logic             cin);
        logic [SLICE-1:0] g;
        logic [SLICE-1:0] p;
        logic [SLICE:0]   c;
        g    = a & b;
        p    = a ^ b;
        c    = '0;
        c[0] = cin;
        for (int i = 0; i < int'(SLICE); i++) begin
            c[i+1] = g[i] | (p[i] & c[i]);
        end
        return {c[SLICE], p ^ c[SLICE-1:0]};
    endfunction

    logic [STAGES-1:0] valid_q;
    logic [STAGES-1:0] op_q;
    logic [STAGES-1:0] carry_q;
    logic [STAGES-1:0] adv;
    logic [WIDTH-1:0]  res_q [STAGES];
    logic [WIDTH-1:0]  a_q   [LAST];
    logic [WIDTH-1:0]  b_q   [LAST];
`ifdef CLA_ADDSUB_FLAGS_EN
    logic [STAGES-1:0] zero_q;
    logic              ovf_q;
`endif

    // A slot may move when any slot from it to the output is empty, or the consumer takes.
    for (genvar k = 0; k < STAGES; k++) begin : g_adv
        assign adv[k] = out_ready | ~(&valid_q[LAST:k]);
    end

    assign in_ready = reset_n & adv[0];

    for (genvar k = 0; k < STAGES; k++) begin : g_slot
        localparam int unsigned LO = k * SLICE;

        logic             src_valid;
        logic             src_op;
        logic             src_cin;
        logic [SLICE-1:0] sa;
        logic [SLICE-1:0] sb;
        logic [SLICE-1:0] sb_eff;
        logic [WIDTH-1:0] src_res;
        logic [SLICE:0]   sum;
        logic             valid_r;
        logic             op_r;
        logic             carry_r;
        logic [WIDTH-1:0] res_r;

        if (k == 0) begin : g_head
            assign src_valid = in_valid & in_ready;
            assign src_op    = in_op;
            assign src_cin   = in_op;
            assign sa        = in_a[LO +: SLICE];
            assign sb        = in_b[LO +: SLICE];
            assign src_res   = '0;
        end else begin : g_body
            assign src_valid = valid_q[k-1];
            assign src_op    = op_q[k-1];
            assign src_cin   = carry_q[k-1];
            assign sa        = a_q[k-1][LO +: SLICE];
            assign sb        = b_q[k-1][LO +: SLICE];
            assign src_res   = res_q[k-1];
        end

        // Subtract is a + ~b + 1; the +1 enters as the slot-0 carry-in.
        assign sb_eff = {SLICE{src_op}} ^ sb;
        assign sum    = cla_slice(sa, sb_eff, src_cin);

        always_ff @(posedge clock or negedge reset_n) begin
            if (!reset_n) begin
                valid_r <= 1'b0;
                op_r    <= 1'b0;
                carry_r <= 1'b0;
                res_r   <= '0;
            end else if (adv[k]) begin
                valid_r <= src_valid;
                if (src_valid) begin
                    op_r    <= src_op;
                    carry_r <= sum[SLICE];
                    res_r   <= src_res | (WIDTH'(sum[SLICE-1:0]) << LO);
                end
            end
        end

        assign valid_q[k] = valid_r;
        assign op_q[k]    = op_r;
        assign carry_q[k] = carry_r;
        assign res_q[k]   = res_r;

        // Only operand bits not yet consumed travel on.
        if (k < LAST) begin : g_opnd
            localparam logic [WIDTH-1:0] HI = ~((WIDTH'(1) << (LO + SLICE)) - WIDTH'(1));
            logic [WIDTH-1:0] a_in;
            logic [WIDTH-1:0] b_in;
            logic [WIDTH-1:0] a_r;
            logic [WIDTH-1:0] b_r;

            if (k == 0) begin : g_first
                assign a_in = in_a;
                assign b_in = in_b;
            end else begin : g_mid
                assign a_in = a_q[k-1];
                assign b_in = b_q[k-1];
            end

            always_ff @(posedge clock or negedge reset_n) begin
                if (!reset_n) begin
                    a_r <= '0;
                    b_r <= '0;
                end else if (adv[k] && src_valid) begin
                    a_r <= a_in & HI;
                    b_r <= b_in & HI;
                end
            end

            assign a_q[k] = a_r;
            assign b_q[k] = b_r;
        end

`ifdef CLA_ADDSUB_FLAGS_EN
        // Running zero-reduction keeps out_zero free of a wide output NOR.
        logic src_zero;
        logic zero_r;

        if (k == 0) begin : g_z0
            assign src_zero = 1'b1;
        end else begin : g_zn
            assign src_zero = zero_q[k-1];
        end

        always_ff @(posedge clock or negedge reset_n) begin
            if (!reset_n) begin
                zero_r <= 1'b0;
            end else if (adv[k] && src_valid) begin
                zero_r <= src_zero & (sum[SLICE-1:0] == '0);
            end
        end

        assign zero_q[k] = zero_r;

        if (k == LAST) begin : g_ovf
            always_ff @(posedge clock or negedge reset_n) begin
                if (!reset_n) begin
                    ovf_q <= 1'b0;
                end else if (adv[k] && src_valid) begin
                    ovf_q <= (sa[SLICE-1] ~^ sb_eff[SLICE-1]) & (sum[SLICE-1] ^ sa[SLICE-1]);
                end
            end
        end
`endif
    end

    assign out_valid  = valid_q[LAST];
    assign out_result = res_q[LAST];
    assign out_cb     = carry_q[LAST] ^ op_q[LAST];
`ifdef CLA_ADDSUB_FLAGS_EN
    assign out_zero   = zero_q[LAST];
    assign out_ovf    = ovf_q;
`endif

endmodule

// File: tb/tb_cla_pipe_addsub.sv
// Directed self-checking bench for cla_pipe_addsub: arithmetic, latency, back-pressure, mid-stream reset.
module tb_cla_pipe_addsub;

    logic        clock;
    logic        reset_n;
    logic        in_valid;
    logic        in_ready;
    logic        in_op;
    logic [31:0] in_a;
    logic [31:0] in_b;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_result;
    logic        out_cb;
`ifdef CLA_ADDSUB_FLAGS_EN
    logic        out_zero;
    logic        out_ovf;
`endif

    int checks   = 0;
    int failures = 0;

    cla_pipe_addsub dut (
        .clock      (clock),
        .reset_n    (reset_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_op      (in_op),
        .in_a       (in_a),
        .in_b       (in_b),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_result (out_result),
`ifdef CLA_ADDSUB_FLAGS_EN
        .out_cb     (out_cb),
        .out_zero   (out_zero),
        .out_ovf    (out_ovf)
`else
        .out_cb     (out_cb)
`endif
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit expired");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Send one op, then wait (bounded) for its result and check latency and value.
    task automatic run_single(input string tag, input logic op, input logic [31:0] a,
                              input logic [31:0] b, input logic [31:0] exp_r, input logic exp_c);
        int n;
        in_valid = 1'b1;
        in_op    = op;
        in_a     = a;
        in_b     = b;
        #1;
        check({tag, " in_ready"}, 32'(in_ready), 32'd1);
        @(posedge clock);
        #1;
        in_valid = 1'b0;
        n = 0;
        while (!out_valid && n < 10) begin
            @(posedge clock);
            #1;
            n++;
        end
        check({tag, " latency"}, 32'(n), 32'd3);
        check({tag, " result"}, out_result, exp_r);
        check({tag, " cb"}, 32'(out_cb), 32'(exp_c));
    endtask

    initial begin
        int sent;
        int recv;
        reset_n   = 1'b0;
        in_valid  = 1'b0;
        in_op     = 1'b0;
        in_a      = '0;
        in_b      = '0;
        out_ready = 1'b1;

        #1;
        check("reset out_valid", 32'(out_valid), 32'd0);
        check("reset in_ready", 32'(in_ready), 32'd0);
        check("reset out_result", out_result, 32'd0);
        check("reset out_cb", 32'(out_cb), 32'd0);
        repeat (2) @(posedge clock);
        #1;
        reset_n = 1'b1;

        run_single("sub basic", 1'b1, 32'h0000_0005, 32'h0000_0003, 32'h0000_0002, 1'b0);
        run_single("sub borrow ripple", 1'b1, 32'h0000_0000, 32'h0000_0001, 32'hFFFF_FFFF, 1'b1);
        run_single("add carry ripple", 1'b0, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 1'b1);
        run_single("add mixed", 1'b0, 32'h1234_5678, 32'h0FED_CBA8, 32'h2222_2220, 1'b0);
        run_single("sub slice borrow", 1'b1, 32'h0000_0100, 32'h0000_0001, 32'h0000_00FF, 1'b0);
        run_single("add msb carry", 1'b0, 32'h8000_0000, 32'h8000_0000, 32'h0000_0000, 1'b1);
        run_single("sub equal", 1'b1, 32'h1234_5678, 32'h1234_5678, 32'h0000_0000, 1'b0);
        @(posedge clock);
        #1;
        check("drain out_valid", 32'(out_valid), 32'd0);

        // Back-pressure: 8 subtracts a=i,b=1; consumer stalls in cycles 3..7.
        sent = 0;
        recv = 0;
        in_op = 1'b1;
        in_b  = 32'd1;
        for (int c = 0; c < 24; c++) begin
            in_valid  = (sent < 8);
            in_a      = 32'(sent);
            out_ready = !(c >= 3 && c <= 7);
            #1;
            check($sformatf("bp in_ready c%0d", c), 32'(in_ready), 32'(!(c >= 4 && c <= 7)));
            if (c >= 4 && c <= 7) begin
                check($sformatf("bp stall valid c%0d", c), 32'(out_valid), 32'd1);
                check($sformatf("bp stall hold c%0d", c), out_result, 32'hFFFF_FFFF);
                check($sformatf("bp stall cb c%0d", c), 32'(out_cb), 32'd1);
            end
            if (out_valid && out_ready) begin
                check($sformatf("bp result %0d", recv), out_result, 32'(recv - 1));
                check($sformatf("bp cb %0d", recv), 32'(out_cb), 32'(recv == 0));
                check($sformatf("bp emit cycle %0d", recv), 32'(c), 32'(8 + recv));
                recv++;
            end
            if (in_valid && in_ready) sent++;
            @(posedge clock);
            #1;
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        check("bp sent count", 32'(sent), 32'd8);
        check("bp recv count", 32'(recv), 32'd8);
        check("bp drained", 32'(out_valid), 32'd0);

        // Mid-stream reset with three ops in flight, the oldest at the output.
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1;
            in_op    = 1'b0;
            in_a     = 32'(100 + i);
            in_b     = 32'd5;
            @(posedge clock);
            #1;
        end
        in_valid = 1'b0;
        @(posedge clock);
        #1;
        check("pre-reset out_valid", 32'(out_valid), 32'd1);
        check("pre-reset result", out_result, 32'd105);
        reset_n = 1'b0;
        #1;
        check("mid reset out_valid", 32'(out_valid), 32'd0);
        check("mid reset in_ready", 32'(in_ready), 32'd0);
        check("mid reset result", out_result, 32'd0);
        check("mid reset cb", 32'(out_cb), 32'd0);
        @(posedge clock);
        #1;
        reset_n = 1'b1;
        run_single("post reset sub", 1'b1, 32'd50, 32'd8, 32'd42, 1'b0);
        @(posedge clock);
        #1;
        for (int i = 0; i < 4; i++) begin
            check($sformatf("no stale %0d", i), 32'(out_valid), 32'd0);
            @(posedge clock);
            #1;
        end

`ifdef CLA_ADDSUB_FLAGS_EN
        run_single("flag ovf sub", 1'b1, 32'h8000_0000, 32'h0000_0001, 32'h7FFF_FFFF, 1'b0);
        check("flag ovf sub ovf", 32'(out_ovf), 32'd1);
        check("flag ovf sub zero", 32'(out_zero), 32'd0);
        run_single("flag zero sub", 1'b1, 32'h1234_5678, 32'h1234_5678, 32'h0000_0000, 1'b0);
        check("flag zero sub zero", 32'(out_zero), 32'd1);
        check("flag zero sub ovf", 32'(out_ovf), 32'd0);
        run_single("flag add ovf", 1'b0, 32'h7FFF_FFFF, 32'h0000_0001, 32'h8000_0000, 1'b0);
        check("flag add ovf ovf", 32'(out_ovf), 32'd1);
        check("flag add ovf zero", 32'(out_zero), 32'd0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
